// File: rtl/axi4lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter with independent round-robin
// write and read paths; grants are registered and held until the response completes.
module axi4lite_arbiter #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   // requester 0
   input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
   input  logic                    s0_awvalid,
   output logic                    s0_awready,
   input  logic [DATA_WIDTH-1:0]   s0_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
   input  logic                    s0_wvalid,
   output logic                    s0_wready,
   output logic [1:0]              s0_bresp,
   output logic                    s0_bvalid,
   input  logic                    s0_bready,
   input  logic [ADDR_WIDTH-1:0]   s0_araddr,
   input  logic                    s0_arvalid,
   output logic                    s0_arready,
   output logic [DATA_WIDTH-1:0]   s0_rdata,
   output logic [1:0]              s0_rresp,
   output logic                    s0_rvalid,
   input  logic                    s0_rready,
   // requester 1
   input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
   input  logic                    s1_awvalid,
   output logic                    s1_awready,
   input  logic [DATA_WIDTH-1:0]   s1_wdata,
   input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
   input  logic                    s1_wvalid,
   output logic                    s1_wready,
   output logic [1:0]              s1_bresp,
   output logic                    s1_bvalid,
   input  logic                    s1_bready,
   input  logic [ADDR_WIDTH-1:0]   s1_araddr,
   input  logic                    s1_arvalid,
   output logic                    s1_arready,
   output logic [DATA_WIDTH-1:0]   s1_rdata,
   output logic [1:0]              s1_rresp,
   output logic                    s1_rvalid,
   input  logic                    s1_rready,
   // shared slave port
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   output logic [1:0]              wr_gnt,
   output logic [1:0]              rd_gnt
);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

   wr_state_t  wr_state_q, wr_state_d;
   rd_state_t  rd_state_q, rd_state_d;
   logic [1:0] wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
   logic       wr_last_q, wr_last_d, rd_last_q, rd_last_d;
   logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic       wr_sel_s, rd_sel_s, aw_rdy_s, w_rdy_s;

   // On a tie the master that did not own the path last time wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
      logic [1:0] g;
      g = 2'b00;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

   assign wr_sel_s = wr_gnt_q[1];
   assign rd_sel_s = rd_gnt_q[1];
   assign wr_gnt   = wr_gnt_q;
   assign rd_gnt   = rd_gnt_q;

   // State, grant and handshake-flag registers for both paths.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         wr_gnt_q   <= 2'b00;
         rd_gnt_q   <= 2'b00;
         wr_last_q  <= 1'b1;
         rd_last_q  <= 1'b1;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_gnt_q   <= wr_gnt_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_last_q  <= wr_last_d;
         rd_last_q  <= rd_last_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   // Write path next state and routing.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_gnt_d   = wr_gnt_q;
      wr_last_d  = wr_last_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      aw_rdy_s   = 1'b0;
      w_rdy_s    = 1'b0;
      m_awaddr   = '0;
      m_awvalid  = 1'b0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s0_bresp   = 2'b00;
      s1_bresp   = 2'b00;
      s0_bvalid  = 1'b0;
      s1_bvalid  = 1'b0;
      if (wr_gnt_q != 2'b00) begin
         m_awaddr = wr_sel_s ? s1_awaddr : s0_awaddr;
         m_wdata  = wr_sel_s ? s1_wdata  : s0_wdata;
         m_wstrb  = wr_sel_s ? s1_wstrb  : s0_wstrb;
      end else begin
         m_awaddr = '0;
      end
      case (wr_state_q)
         W_IDLE: begin
            wr_gnt_d = rr_pick({s1_awvalid, s0_awvalid}, wr_last_q);
            if (wr_gnt_d != 2'b00) begin
               wr_state_d = W_XFER;
            end else begin
               wr_state_d = W_IDLE;
            end
         end
         W_XFER: begin
            m_awvalid = !aw_done_q && (wr_sel_s ? s1_awvalid : s0_awvalid);
            m_wvalid  = !w_done_q  && (wr_sel_s ? s1_wvalid  : s0_wvalid);
            aw_rdy_s  = !aw_done_q && m_awready;
            w_rdy_s   = !w_done_q  && m_wready;
            aw_done_d = aw_done_q | (m_awvalid & m_awready);
            w_done_d  = w_done_q  | (m_wvalid  & m_wready);
            if (aw_done_d && w_done_d) begin
               wr_state_d = W_RESP;
            end else begin
               wr_state_d = W_XFER;
            end
         end
         W_RESP: begin
            m_bready  = wr_sel_s ? s1_bready : s0_bready;
            s0_bvalid = !wr_sel_s && m_bvalid;
            s1_bvalid =  wr_sel_s && m_bvalid;
            s0_bresp  = wr_sel_s ? 2'b00 : m_bresp;
            s1_bresp  = wr_sel_s ? m_bresp : 2'b00;
            if (m_bvalid && m_bready) begin
               wr_state_d = W_IDLE;
               wr_gnt_d   = 2'b00;
               wr_last_d  = wr_sel_s;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end else begin
               wr_state_d = W_RESP;
            end
         end
         default: begin
            wr_state_d = W_IDLE;
            wr_gnt_d   = 2'b00;
         end
      endcase
      s0_awready = !wr_sel_s && aw_rdy_s;
      s1_awready =  wr_sel_s && aw_rdy_s;
      s0_wready  = !wr_sel_s && w_rdy_s;
      s1_wready  =  wr_sel_s && w_rdy_s;
   end

   // Read path next state and routing.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_gnt_d   = rd_gnt_q;
      rd_last_d  = rd_last_q;
      m_araddr   = '0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      s0_rdata   = '0;
      s1_rdata   = '0;
      s0_rresp   = 2'b00;
      s1_rresp   = 2'b00;
      s0_rvalid  = 1'b0;
      s1_rvalid  = 1'b0;
      if (rd_gnt_q != 2'b00) begin
         m_araddr = rd_sel_s ? s1_araddr : s0_araddr;
      end else begin
         m_araddr = '0;
      end
      case (rd_state_q)
         R_IDLE: begin
            rd_gnt_d = rr_pick({s1_arvalid, s0_arvalid}, rd_last_q);
            if (rd_gnt_d != 2'b00) begin
               rd_state_d = R_ADDR;
            end else begin
               rd_state_d = R_IDLE;
            end
         end
         R_ADDR: begin
            m_arvalid  = rd_sel_s ? s1_arvalid : s0_arvalid;
            s0_arready = !rd_sel_s && m_arready;
            s1_arready =  rd_sel_s && m_arready;
            if (m_arvalid && m_arready) begin
               rd_state_d = R_DATA;
            end else begin
               rd_state_d = R_ADDR;
            end
         end
         R_DATA: begin
            m_rready  = rd_sel_s ? s1_rready : s0_rready;
            s0_rvalid = !rd_sel_s && m_rvalid;
            s1_rvalid =  rd_sel_s && m_rvalid;
            s0_rdata  = rd_sel_s ? '0 : m_rdata;
            s1_rdata  = rd_sel_s ? m_rdata : '0;
            s0_rresp  = rd_sel_s ? 2'b00 : m_rresp;
            s1_rresp  = rd_sel_s ? m_rresp : 2'b00;
            if (m_rvalid && m_rready) begin
               rd_state_d = R_IDLE;
               rd_gnt_d   = 2'b00;
               rd_last_d  = rd_sel_s;
            end else begin
               rd_state_d = R_DATA;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
            rd_gnt_d   = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter: hand-driven requesters and slave,
// hand-computed expectations checked with immediate assertions.
module tb_axi4lite_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
   logic       s0_awvalid, s1_awvalid, s0_awready, s1_awready;
   logic [7:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
   logic [0:0] s0_wstrb, s1_wstrb, m_wstrb;
   logic       s0_wvalid, s1_wvalid, s0_wready, s1_wready;
   logic [1:0] s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
   logic       s0_bvalid, s1_bvalid, s0_bready, s1_bready;
   logic       s0_arvalid, s1_arvalid, s0_arready, s1_arready;
   logic       s0_rvalid, s1_rvalid, s0_rready, s1_rready;
   logic       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic       m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0] wr_gnt, rd_gnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   axi4lite_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
      .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
      .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
      .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
      .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
      .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
      .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      s0_awaddr = 2'd0; s1_awaddr = 2'd0; s0_araddr = 2'd0; s1_araddr = 2'd0;
      s0_awvalid = 1'b0; s1_awvalid = 1'b0; s0_wvalid = 1'b0; s1_wvalid = 1'b0;
      s0_wdata = 8'h00; s1_wdata = 8'h00; s0_wstrb = 1'b1; s1_wstrb = 1'b1;
      s0_bready = 1'b0; s1_bready = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
      s0_rready = 1'b0; s1_rready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rdata = 8'h00; m_rresp = 2'b00; m_rvalid = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
      chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
      chk("rst_m_awvalid", 32'(m_awvalid), 32'h0);
      chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
      chk("rst_m_awaddr", 32'(m_awaddr), 32'h0);

      // Tie after reset: master 0 first, master 1 after the B handshake
      s0_awvalid = 1'b1; s0_awaddr = 2'd1; s0_wvalid = 1'b1; s0_wdata = 8'h11;
      s1_awvalid = 1'b1; s1_awaddr = 2'd2; s1_wvalid = 1'b1; s1_wdata = 8'h22;
      #1;
      chk("tie_idle_gnt", 32'(wr_gnt), 32'h0);
      chk("tie_idle_awvalid", 32'(m_awvalid), 32'h0);
      cyc();
      chk("tie_gnt0", 32'(wr_gnt), 32'h1);
      chk("tie_m_awaddr", 32'(m_awaddr), 32'h1);
      chk("tie_m_wdata", 32'(m_wdata), 32'h11);
      m_awready = 1'b1; m_wready = 1'b1;
      #1;
      chk("tie_s0_awready", 32'(s0_awready), 32'h1);
      chk("tie_s1_awready", 32'(s1_awready), 32'h0);
      chk("tie_s0_wready", 32'(s0_wready), 32'h1);
      cyc();
      s0_awvalid = 1'b0; s0_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bresp = 2'b10; s0_bready = 1'b1;
      #1;
      chk("resp_m_awvalid", 32'(m_awvalid), 32'h0);
      chk("resp_s0_bvalid", 32'(s0_bvalid), 32'h1);
      chk("resp_s0_bresp", 32'(s0_bresp), 32'h2);
      chk("resp_s1_bvalid", 32'(s1_bvalid), 32'h0);
      chk("resp_m_bready", 32'(m_bready), 32'h1);
      cyc();
      m_bvalid = 1'b0; s0_bready = 1'b0;
      #1;
      chk("after_b_gnt", 32'(wr_gnt), 32'h0);
      cyc();
      chk("tie_gnt1", 32'(wr_gnt), 32'h2);
      chk("tie_gnt1_awaddr", 32'(m_awaddr), 32'h2);
      chk("tie_gnt1_wdata", 32'(m_wdata), 32'h22);
      m_awready = 1'b1; m_wready = 1'b1;
      cyc();
      s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; s1_bready = 1'b1; m_bresp = 2'b00;
      #1;
      chk("s1_bvalid", 32'(s1_bvalid), 32'h1);
      cyc();
      m_bvalid = 1'b0; s1_bready = 1'b0;

      // W valid three cycles ahead of AW; slave takes AW first, W later
      s0_wvalid = 1'b1; s0_wdata = 8'hA5;
      cyc(); cyc(); cyc();
      chk("early_w_gnt", 32'(wr_gnt), 32'h0);
      chk("early_w_m_wvalid", 32'(m_wvalid), 32'h0);
      s0_awvalid = 1'b1; s0_awaddr = 2'd3;
      cyc();
      chk("early_w_gnt0", 32'(wr_gnt), 32'h1);
      m_awready = 1'b1;
      #1;
      chk("early_w_aw_hs", 32'(m_awvalid & m_awready), 32'h1);
      chk("early_w_w_nohs", 32'(m_wvalid & m_wready), 32'h0);
      cyc();
      chk("aw_forced_m_awvalid", 32'(m_awvalid), 32'h0);
      chk("aw_forced_s0_awready", 32'(s0_awready), 32'h0);
      chk("aw_done_m_wvalid", 32'(m_wvalid), 32'h1);
      cyc();
      chk("w_wait_gnt", 32'(wr_gnt), 32'h1);
      chk("w_wait_m_awvalid", 32'(m_awvalid), 32'h0);
      m_wready = 1'b1;
      #1;
      chk("w_hs", 32'(m_wvalid & m_wready), 32'h1);
      cyc();
      s0_bready = 1'b1;
      #1;
      chk("early_w_resp_m_wvalid", 32'(m_wvalid), 32'h0);
      chk("early_w_resp_m_awvalid", 32'(m_awvalid), 32'h0);
      chk("early_w_resp_bready", 32'(m_bready), 32'h1);
      s0_awvalid = 1'b0; s0_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1;
      cyc();
      m_bvalid = 1'b0; s0_bready = 1'b0;
      #1;
      chk("early_w_done_gnt", 32'(wr_gnt), 32'h0);

      // Concurrent s0 write and s1 read
      s0_awvalid = 1'b1; s0_awaddr = 2'd2; s0_wvalid = 1'b1; s0_wdata = 8'hA5;
      s1_arvalid = 1'b1; s1_araddr = 2'd2;
      cyc();
      chk("conc_wr_gnt", 32'(wr_gnt), 32'h1);
      chk("conc_rd_gnt", 32'(rd_gnt), 32'h2);
      chk("conc_m_araddr", 32'(m_araddr), 32'h2);
      chk("conc_m_wdata", 32'(m_wdata), 32'hA5);
      chk("conc_m_wstrb", 32'(m_wstrb), 32'h1);
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      #1;
      chk("conc_s1_arready", 32'(s1_arready), 32'h1);
      chk("conc_s0_arready", 32'(s0_arready), 32'h0);
      cyc();
      s0_awvalid = 1'b0; s0_wvalid = 1'b0; s1_arvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 8'h3C; m_rresp = 2'b01; s1_rready = 1'b1;
      m_bvalid = 1'b1; s0_bready = 1'b1;
      #1;
      chk("conc_s1_rdata", 32'(s1_rdata), 32'h3C);
      chk("conc_s1_rresp", 32'(s1_rresp), 32'h1);
      chk("conc_s1_rvalid", 32'(s1_rvalid), 32'h1);
      chk("conc_s0_rvalid", 32'(s0_rvalid), 32'h0);
      chk("conc_m_rready", 32'(m_rready), 32'h1);
      chk("conc_s0_bvalid", 32'(s0_bvalid), 32'h1);
      cyc();
      m_rvalid = 1'b0; s1_rready = 1'b0; m_bvalid = 1'b0; s0_bready = 1'b0;
      #1;
      chk("conc_done_wr", 32'(wr_gnt), 32'h0);
      chk("conc_done_rd", 32'(rd_gnt), 32'h0);

      // Reset in W_XFER after AW only (s0 owned the path last)
      s1_awvalid = 1'b1; s1_awaddr = 2'd1; s1_wvalid = 1'b1;
      cyc();
      chk("rstx_gnt1", 32'(wr_gnt), 32'h2);
      m_awready = 1'b1;
      cyc();
      m_awready = 1'b0;
      #1;
      chk("rstx_aw_only_wvalid", 32'(m_wvalid), 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0; s0_awvalid = 1'b1; s0_wvalid = 1'b1; m_wready = 1'b1;
      #1;
      chk("rstx_m_wvalid", 32'(m_wvalid), 32'h0);
      chk("rstx_wr_gnt", 32'(wr_gnt), 32'h0);
      chk("rstx_s1_wready", 32'(s1_wready), 32'h0);
      cyc();
      chk("rstx_tie_gnt0", 32'(wr_gnt), 32'h1);
      m_awready = 1'b1;
      cyc();
      s0_awvalid = 1'b0; s0_wvalid = 1'b0; s1_awvalid = 1'b0; s1_wvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; s0_bready = 1'b1;
      cyc();
      m_bvalid = 1'b0; s0_bready = 1'b0;

      // Slave stalls B with bready low; s1 must stay blocked
      s0_awvalid = 1'b1; s0_wvalid = 1'b1;
      cyc();
      m_awready = 1'b1; m_wready = 1'b1;
      cyc();
      s0_awvalid = 1'b0; s0_wvalid = 1'b0;
      s1_awvalid = 1'b1; s1_wvalid = 1'b1; m_bvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bstall_gnt", 32'(wr_gnt), 32'h1);
         chk("bstall_s1_awready", 32'(s1_awready), 32'h0);
         chk("bstall_m_bready", 32'(m_bready), 32'h0);
         cyc();
      end
      s0_bready = 1'b1;
      cyc();
      s0_bready = 1'b0; m_bvalid = 1'b0;
      #1;
      chk("bstall_released", 32'(wr_gnt), 32'h0);
      cyc();
      chk("bstall_s1_gnt", 32'(wr_gnt), 32'h2);
      cyc();
      s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; s1_bready = 1'b1;
      cyc();
      m_bvalid = 1'b0; s1_bready = 1'b0;

      // Back-to-back reads from both masters alternate
      s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1;
      m_rvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] exp_g;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         cyc();
         chk("alt_addr_gnt", 32'(rd_gnt), 32'(exp_g));
         cyc();
         chk("alt_data_gnt", 32'(rd_gnt), 32'(exp_g));
         chk("alt_rvalid", 32'({s1_rvalid, s0_rvalid}), 32'(exp_g));
         cyc();
      end
      s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0;
      cyc();
      chk("alt_end_gnt", 32'(rd_gnt), 32'h0);
      chk("alt_end_arvalid", 32'(m_arvalid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
